// File: rtl/ext_int_filt_pkg.sv
// rtl/ext_int_filt_pkg.sv - register map and PEND_ID layout for ext_int_filt
package ext_int_filt_pkg;

  localparam int ADDR_GER       = 0;
  localparam int ADDR_IER_RISE  = 1;
  localparam int ADDR_IER_FALL  = 2;
  localparam int ADDR_IER_LEVEL = 3;
  localparam int ADDR_IPOL      = 4;
  localparam int ADDR_ISR       = 5;
  localparam int ADDR_PIN       = 6;
  localparam int ADDR_FILT      = 7;
  localparam int ADDR_PEND_ID   = 8;
  localparam int ADDR_ISR_SET   = 9;
  localparam int NUM_REGS       = 10;

  localparam int PEND_IDX_W = 5;

  // The "any pending" flag always sits in the data MSB.
  function automatic int pend_valid_bit(input int dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/ext_int_sync_filt.sv
// rtl/ext_int_sync_filt.sv - one channel: pin synchronizer, debounce filter, delayed copy
module ext_int_sync_filt #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTw       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pin_i,
  input  logic [FILTw-1:0] filt_cnt_i,
  output logic             filt_o,
  output logic             filt_dly_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILTw-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   filt_dly_q, filt_dly_d;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // A new level is accepted only after it has been seen filt_cnt_i+1 cycles in a row.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], pin_i};
    cnt_d      = cnt_q;
    filt_d     = filt_q;
    filt_dly_d = filt_q;
    if (sync_bit == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == filt_cnt_i) begin
      filt_d = sync_bit;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      filt_q     <= 1'b0;
      filt_dly_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      filt_q     <= filt_d;
      filt_dly_q <= filt_dly_d;
    end
  end

  assign filt_o     = filt_q;
  assign filt_dly_o = filt_dly_q;

endmodule

// File: rtl/ext_int_filt.sv
// rtl/ext_int_filt.sv - Wishbone external interrupt controller with edge/level modes and debounce
module ext_int_filt #(
  parameter int EXT_INT_NUM = 3,
  parameter int Aw          = 4,
  parameter int SELw        = 4,
  parameter int TAGw        = 3,
  parameter int Dw          = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILTw       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [Dw-1:0]          sa_dat_i,
  input  logic [SELw-1:0]        sa_sel_i,
  input  logic [Aw-1:0]          sa_addr_i,
  input  logic [TAGw-1:0]        sa_tag_i,
  input  logic                   sa_stb_i,
  input  logic                   sa_cyc_i,
  input  logic                   sa_we_i,
  output logic [Dw-1:0]          sa_dat_o,
  output logic                   sa_ack_o,
  output logic                   sa_err_o,
  output logic                   sa_rty_o,
  input  logic [EXT_INT_NUM-1:0] ext_int_i,
  output logic                   ext_int_o
);
  import ext_int_filt_pkg::*;

  localparam int N = EXT_INT_NUM;

  logic             ger_q, ger_d;
  logic [N-1:0]     ier_rise_q, ier_rise_d;
  logic [N-1:0]     ier_fall_q, ier_fall_d;
  logic [N-1:0]     ier_level_q, ier_level_d;
  logic [N-1:0]     ipol_q, ipol_d;
  logic [N-1:0]     isr_q, isr_d;
  logic [FILTw-1:0] filt_cnt_q, filt_cnt_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [Dw-1:0]    dat_q, dat_d;

  logic [N-1:0]     pin_filt, pin_filt_dly;
  logic [N-1:0]     w1c, w1s, trig, wdata_n;
  logic [Dw-1:0]    rd_mux, pend_id;
  logic             access, mapped, wr;
  logic             unused_ok;

  assign unused_ok = ^{sa_sel_i, sa_tag_i, sa_dat_i};

  // ack/err gate new accesses so a held strobe produces exactly one transaction.
  assign access  = sa_stb_i & sa_cyc_i & ~ack_q & ~err_q;
  assign mapped  = sa_addr_i < Aw'(NUM_REGS);
  assign wr      = access & mapped & sa_we_i;
  assign wdata_n = sa_dat_i[N-1:0];

  for (genvar g = 0; g < N; g++) begin : g_ch
    ext_int_sync_filt #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTw      (FILTw)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .pin_i     (ext_int_i[g]),
      .filt_cnt_i(filt_cnt_q),
      .filt_o    (pin_filt[g]),
      .filt_dly_o(pin_filt_dly[g])
    );
  end

  always_comb begin
    trig = '0;
    if (ger_q) begin
      trig = (ier_rise_q  & pin_filt & ~pin_filt_dly)
           | (ier_fall_q  & ~pin_filt & pin_filt_dly)
           | (ier_level_q & (pin_filt ^ ipol_q));
    end
  end

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    pend_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (isr_q[i]) pend_id[PEND_IDX_W-1:0] = PEND_IDX_W'(i);
    end
    pend_id[pend_valid_bit(Dw)] = |isr_q;
  end

  always_comb begin
    rd_mux = '0;
    case (sa_addr_i)
      Aw'(ADDR_GER):       rd_mux = Dw'(ger_q);
      Aw'(ADDR_IER_RISE):  rd_mux = Dw'(ier_rise_q);
      Aw'(ADDR_IER_FALL):  rd_mux = Dw'(ier_fall_q);
      Aw'(ADDR_IER_LEVEL): rd_mux = Dw'(ier_level_q);
      Aw'(ADDR_IPOL):      rd_mux = Dw'(ipol_q);
      Aw'(ADDR_ISR):       rd_mux = Dw'(isr_q);
      Aw'(ADDR_PIN):       rd_mux = Dw'(pin_filt);
      Aw'(ADDR_FILT):      rd_mux = Dw'(filt_cnt_q);
      Aw'(ADDR_PEND_ID):   rd_mux = pend_id;
      default:             rd_mux = '0;
    endcase
  end

  always_comb begin
    ger_d       = ger_q;
    ier_rise_d  = ier_rise_q;
    ier_fall_d  = ier_fall_q;
    ier_level_d = ier_level_q;
    ipol_d      = ipol_q;
    filt_cnt_d  = filt_cnt_q;
    w1c         = '0;
    w1s         = '0;
    if (wr) begin
      case (sa_addr_i)
        Aw'(ADDR_GER):       ger_d       = sa_dat_i[0];
        Aw'(ADDR_IER_RISE):  ier_rise_d  = wdata_n;
        Aw'(ADDR_IER_FALL):  ier_fall_d  = wdata_n;
        Aw'(ADDR_IER_LEVEL): ier_level_d = wdata_n;
        Aw'(ADDR_IPOL):      ipol_d      = wdata_n;
        Aw'(ADDR_ISR):       w1c         = wdata_n;
        Aw'(ADDR_FILT):      filt_cnt_d  = sa_dat_i[FILTw-1:0];
        Aw'(ADDR_ISR_SET):   w1s         = wdata_n;
        default: ;
      endcase
    end
    // Sets (software or hardware) win over a same-cycle clear.
    isr_d = (isr_q & ~w1c) | w1s | trig;
    ack_d = access & mapped;
    err_d = access & ~mapped;
    dat_d = (access & mapped & ~sa_we_i) ? rd_mux : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ger_q       <= 1'b0;
      ier_rise_q  <= '0;
      ier_fall_q  <= '0;
      ier_level_q <= '0;
      ipol_q      <= '0;
      isr_q       <= '0;
      filt_cnt_q  <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      dat_q       <= '0;
    end else begin
      ger_q       <= ger_d;
      ier_rise_q  <= ier_rise_d;
      ier_fall_q  <= ier_fall_d;
      ier_level_q <= ier_level_d;
      ipol_q      <= ipol_d;
      isr_q       <= isr_d;
      filt_cnt_q  <= filt_cnt_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      dat_q       <= dat_d;
    end
  end

  assign sa_dat_o  = dat_q;
  assign sa_ack_o  = ack_q;
  assign sa_err_o  = err_q;
  assign sa_rty_o  = 1'b0;
  assign ext_int_o = |isr_q;

endmodule

// File: tb/tb_ext_int_filt.sv
// tb/tb_ext_int_filt.sv - directed self-checking bench for ext_int_filt
module tb_ext_int_filt;

  localparam int A_GER = 0, A_RISE = 1, A_FALL = 2, A_LEVEL = 3, A_IPOL = 4;
  localparam int A_ISR = 5, A_PIN = 6, A_FILT = 7, A_PEND = 8, A_ISET = 9;

  logic        clk;
  logic        reset;
  logic [31:0] sa_dat_i;
  logic [3:0]  sa_sel_i;
  logic [3:0]  sa_addr_i;
  logic [2:0]  sa_tag_i;
  logic        sa_stb_i, sa_cyc_i, sa_we_i;
  logic [31:0] sa_dat_o;
  logic        sa_ack_o, sa_err_o, sa_rty_o;
  logic [2:0]  ext_int_i;
  logic        ext_int_o;

  int tests_run;
  int tests_failed;

  ext_int_filt dut (
    .clk      (clk),
    .reset    (reset),
    .sa_dat_i (sa_dat_i),
    .sa_sel_i (sa_sel_i),
    .sa_addr_i(sa_addr_i),
    .sa_tag_i (sa_tag_i),
    .sa_stb_i (sa_stb_i),
    .sa_cyc_i (sa_cyc_i),
    .sa_we_i  (sa_we_i),
    .sa_dat_o (sa_dat_o),
    .sa_ack_o (sa_ack_o),
    .sa_err_o (sa_err_o),
    .sa_rty_o (sa_rty_o),
    .ext_int_i(ext_int_i),
    .ext_int_o(ext_int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Bus driver; called at posedge+1 and returns at posedge+1.
  task automatic wb_xfer(input logic we, input int addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic ack, output logic err);
    sa_we_i   = we;
    sa_addr_i = 4'(addr);
    sa_dat_i  = wdata;
    sa_stb_i  = 1'b1;
    sa_cyc_i  = 1'b1;
    ack = 1'b0; err = 1'b0; rdata = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (sa_ack_o || sa_err_o) begin
        ack = sa_ack_o; err = sa_err_o; rdata = sa_dat_o;
        break;
      end
    end
    sa_stb_i = 1'b0;
    sa_cyc_i = 1'b0;
    sa_we_i  = 1'b0;
    if (!(ack || err)) begin
      tests_run++; tests_failed++;
      $display("FAIL bus_timeout: addr %0d got no ack/err within 4 cycles", addr);
    end
  endtask

  task automatic wb_write(input int addr, input logic [31:0] wdata);
    logic [31:0] d; logic a, e;
    wb_xfer(1'b1, addr, wdata, d, a, e);
  endtask

  task automatic wb_read(input int addr, output logic [31:0] rdata);
    logic a, e;
    wb_xfer(1'b0, addr, 32'h0, rdata, a, e);
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    tests_run++;
    if ({sa_ack_o, sa_err_o, sa_rty_o, ext_int_o, sa_dat_o} !== 36'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ack=%b err=%b rty=%b int=%b dat=%h required all 0",
               sa_ack_o, sa_err_o, sa_rty_o, ext_int_o, sa_dat_o);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    wb_read(A_GER, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++; $display("FAIL reset_ger: got %h required %h", rd, 32'h0);
    end
    wb_read(A_ISR, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++; $display("FAIL reset_isr: got %h required %h", rd, 32'h0);
    end
  endtask

  task automatic test_rise;
    logic [31:0] rd;
    wb_write(A_GER, 32'h1);
    wb_write(A_RISE, 32'h1);
    wb_write(A_FILT, 32'h0);
    ext_int_i[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      tests_run++;
      if (ext_int_o !== (k >= 4)) begin
        tests_failed++;
        $display("FAIL rise_latency edge %0d: got %b required %b", k, ext_int_o, (k >= 4));
      end
    end
    wb_read(A_ISR, rd);
    tests_run++;
    if (rd !== 32'h1) begin
      tests_failed++; $display("FAIL rise_isr: got %h required %h", rd, 32'h1);
    end
    wb_read(A_PEND, rd);
    tests_run++;
    if (rd !== 32'h8000_0000) begin
      tests_failed++; $display("FAIL rise_pend_id: got %h required %h", rd, 32'h8000_0000);
    end
    wb_write(A_ISR, 32'h1);
    wb_read(A_ISR, rd);
    tests_run++;
    if (rd !== 32'h0 || ext_int_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rise_w1c: got isr=%h int=%b required isr=0 int=0", rd, ext_int_o);
    end
    ext_int_i[0] = 1'b0;
    wait_cycles(8);
  endtask

  task automatic test_debounce;
    logic [31:0] rd;
    wb_write(A_RISE, 32'h2);
    wb_write(A_FALL, 32'h2);
    wb_write(A_FILT, 32'h5);
    ext_int_i[1] = 1'b1;
    wait_cycles(4);
    ext_int_i[1] = 1'b0;
    wait_cycles(12);
    wb_read(A_ISR, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++; $display("FAIL debounce_glitch: got %h required %h", rd, 32'h0);
    end
    ext_int_i[1] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      tests_run++;
      if (ext_int_o !== (k >= 9)) begin
        tests_failed++;
        $display("FAIL debounce_latency edge %0d: got %b required %b", k, ext_int_o, (k >= 9));
      end
      if (k == 8) ext_int_i[1] = 1'b0;
    end
    wb_read(A_ISR, rd);
    tests_run++;
    if (rd !== 32'h2) begin
      tests_failed++; $display("FAIL debounce_rise_isr: got %h required %h", rd, 32'h2);
    end
    wb_write(A_ISR, 32'h2);
    wb_read(A_ISR, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++; $display("FAIL debounce_cleared: got %h required %h", rd, 32'h0);
    end
    wait_cycles(10);
    wb_read(A_ISR, rd);
    tests_run++;
    if (rd !== 32'h2) begin
      tests_failed++; $display("FAIL debounce_fall_isr: got %h required %h", rd, 32'h2);
    end
    wb_write(A_ISR, 32'h2);
    wb_write(A_RISE, 32'h0);
    wb_write(A_FALL, 32'h0);
    wb_write(A_FILT, 32'h0);
  endtask

  task automatic test_level;
    logic [31:0] rd;
    wb_write(A_IPOL, 32'h4);
    wb_write(A_LEVEL, 32'h4);
    wb_read(A_ISR, rd);
    tests_run++;
    if (rd !== 32'h4) begin
      tests_failed++; $display("FAIL level_set: got %h required %h", rd, 32'h4);
    end
    wb_write(A_ISR, 32'h4);
    wb_read(A_ISR, rd);
    tests_run++;
    if (rd !== 32'h4) begin
      tests_failed++; $display("FAIL level_hold_w1c: got %h required %h", rd, 32'h4);
    end
    ext_int_i[2] = 1'b1;
    wait_cycles(8);
    wb_write(A_ISR, 32'h4);
    wb_read(A_ISR, rd);
    tests_run++;
    if (rd !== 32'h0 || ext_int_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL level_release_w1c: got isr=%h int=%b required isr=0 int=0", rd, ext_int_o);
    end
    wb_write(A_LEVEL, 32'h0);
    wb_write(A_IPOL, 32'h0);
  endtask

  task automatic test_priority;
    logic [31:0] rd;
    wb_write(A_ISET, 32'h6);
    wb_read(A_PEND, rd);
    tests_run++;
    if (rd !== 32'h8000_0001) begin
      tests_failed++; $display("FAIL prio_set_110: got %h required %h", rd, 32'h8000_0001);
    end
    wb_write(A_ISR, 32'h2);
    wb_read(A_PEND, rd);
    tests_run++;
    if (rd !== 32'h8000_0002) begin
      tests_failed++; $display("FAIL prio_after_w1c: got %h required %h", rd, 32'h8000_0002);
    end
    wb_write(A_ISR, 32'h4);
    wb_read(A_PEND, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++; $display("FAIL prio_empty: got %h required %h", rd, 32'h0);
    end
    // Line the W1C edge up with the rising-edge trigger (edge 4 after the pin change).
    wb_write(A_RISE, 32'h1);
    ext_int_i[0] = 1'b1;
    wait_cycles(3);
    wb_write(A_ISR, 32'h1);
    wb_read(A_ISR, rd);
    tests_run++;
    if (rd !== 32'h1) begin
      tests_failed++; $display("FAIL prio_set_beats_clear: got %h required %h", rd, 32'h1);
    end
    wb_write(A_ISR, 32'h1);
    wb_write(A_RISE, 32'h0);
    ext_int_i[0] = 1'b0;
    wait_cycles(6);
  endtask

  task automatic test_bus;
    logic [31:0] rd;
    logic a, e;
    wb_xfer(1'b0, 12, 32'h0, rd, a, e);
    tests_run++;
    if (e !== 1'b1 || a !== 1'b0 || rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL bus_unmapped_read: got err=%b ack=%b dat=%h required err=1 ack=0 dat=0", e, a, rd);
    end
    wb_xfer(1'b1, 12, 32'hFFFF_FFFF, rd, a, e);
    wb_write(A_PIN, 32'hFFFF_FFFF);
    wb_read(A_PIN, rd);
    tests_run++;
    if (rd !== 32'h4) begin
      tests_failed++; $display("FAIL bus_pin_readonly: got %h required %h", rd, 32'h4);
    end
    wb_read(A_GER, rd);
    tests_run++;
    if (rd !== 32'h1) begin
      tests_failed++; $display("FAIL bus_unmapped_write: got ger=%h required %h", rd, 32'h1);
    end
    sa_addr_i = 4'(A_GER);
    sa_stb_i  = 1'b1;
    sa_cyc_i  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      tests_run++;
      if (sa_ack_o !== 1'b0 || sa_err_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL bus_stb_no_cyc cycle %0d: got ack=%b err=%b required 0 0", k, sa_ack_o, sa_err_o);
      end
    end
    sa_stb_i = 1'b0;
    wb_write(A_GER, 32'h0);
    wb_write(A_RISE, 32'h1);
    ext_int_i[0] = 1'b1;
    wait_cycles(8);
    wb_read(A_ISR, rd);
    tests_run++;
    if (rd !== 32'h0 || ext_int_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL bus_ger_off: got isr=%h int=%b required isr=0 int=0", rd, ext_int_o);
    end
    wb_write(A_ISET, 32'h1);
    wb_read(A_ISR, rd);
    tests_run++;
    if (rd !== 32'h1) begin
      tests_failed++; $display("FAIL bus_ger_off_w1s: got %h required %h", rd, 32'h1);
    end
    wb_write(A_ISR, 32'h1);
    wb_read(A_ISR, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++; $display("FAIL bus_ger_off_w1c: got %h required %h", rd, 32'h0);
    end
    wb_write(A_RISE, 32'h0);
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    wb_write(A_GER, 32'h1);
    wb_write(A_FILT, 32'd20);
    wb_write(A_ISET, 32'h3);
    wb_read(A_ISR, rd);
    tests_run++;
    if (rd !== 32'h3) begin
      tests_failed++; $display("FAIL rst_pre_isr: got %h required %h", rd, 32'h3);
    end
    ext_int_i = 3'b111;
    wait_cycles(3);
    sa_addr_i = 4'(A_ISR);
    sa_we_i   = 1'b0;
    sa_stb_i  = 1'b1;
    sa_cyc_i  = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (sa_ack_o !== 1'b1) begin
      tests_failed++; $display("FAIL rst_pre_ack: got %b required 1", sa_ack_o);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({sa_ack_o, sa_err_o, ext_int_o, sa_dat_o} !== 35'h0) begin
      tests_failed++;
      $display("FAIL rst_immediate: got ack=%b err=%b int=%b dat=%h required all 0",
               sa_ack_o, sa_err_o, ext_int_o, sa_dat_o);
    end
    sa_stb_i = 1'b0;
    sa_cyc_i = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_cycles(30);
    tests_run++;
    if (ext_int_o !== 1'b0) begin
      tests_failed++; $display("FAIL rst_no_spurious_int: got %b required 0", ext_int_o);
    end
    wb_read(A_ISR, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++; $display("FAIL rst_isr: got %h required %h", rd, 32'h0);
    end
    wb_read(A_FILT, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++; $display("FAIL rst_filt: got %h required %h", rd, 32'h0);
    end
    wb_read(A_GER, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++; $display("FAIL rst_ger: got %h required %h", rd, 32'h0);
    end
    wb_read(A_PIN, rd);
    tests_run++;
    if (rd !== 32'h7) begin
      tests_failed++; $display("FAIL rst_pin: got %h required %h", rd, 32'h7);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset     = 1'b1;
    sa_dat_i  = '0;
    sa_sel_i  = 4'hF;
    sa_addr_i = '0;
    sa_tag_i  = '0;
    sa_stb_i  = 1'b0;
    sa_cyc_i  = 1'b0;
    sa_we_i   = 1'b0;
    ext_int_i = '0;
    #1;
    test_reset;
    test_rise;
    test_debounce;
    test_level;
    test_priority;
    test_bus;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
